// File: rtl/apb_request_arbiter.sv
// apb_request_arbiter: round-robin sharing of one APB master processor-side bus
// between NREQ requesters, one transfer at a time, with a WAIT-state timeout.
module apb_request_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_write,
  input  logic [2*NREQ-1:0]   req_sel,
  input  logic [8*NREQ-1:0]   req_addr,
  input  logic [8*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]     req_ready,
  output logic                resp_valid,
  output logic [1:0]          resp_id,
  output logic [7:0]          resp_rdata,
  output logic                resp_err,
  output logic                m_start,
  output logic                m_write,
  output logic [1:0]          m_sel,
  output logic [7:0]          m_addr,
  output logic [7:0]          m_wdata,
  input  logic                m_stable,
  input  logic [7:0]          m_rdata,
  output logic                busy
);

  localparam int unsigned IDW = 2;
  localparam int unsigned SW  = 2;
  localparam int unsigned DW  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cur_id;
  logic [CW-1:0]    cnt;

  logic [NREQ-1:0]  rot_c;
  logic [IDW:0]     sum_c;
  logic [IDW-1:0]   win_id_c;
  logic [IDW-1:0]   next_ptr_c;
  logic             any_req_c;

  // Rotate requests so bit 0 is the rr pointer position, then take the lowest set bit.
  always_comb begin
    rot_c     = NREQ'({req_valid, req_valid} >> rr_ptr);
    sum_c     = '0;
    win_id_c  = '0;
    any_req_c = 1'b0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (rot_c[k]) begin
        sum_c = {1'b0, rr_ptr} + (IDW+1)'(k);
        if (sum_c >= (IDW+1)'(NREQ)) begin
          sum_c = sum_c - (IDW+1)'(NREQ);
        end
        win_id_c  = sum_c[IDW-1:0];
        any_req_c = 1'b1;
      end
    end
    next_ptr_c = (32'(win_id_c) == NREQ - 1) ? '0 : win_id_c + IDW'(1);
  end

  // Accept pulse is combinational and only offered while idle and out of reset.
  assign req_ready = (!reset && state == S_IDLE && any_req_c) ? (NREQ'(1) << win_id_c) : '0;

  // Transfer sequencer with registered master and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      m_start    <= 1'b0;
      m_write    <= 1'b0;
      m_sel      <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      busy       <= 1'b0;
    end else begin
      m_start    <= 1'b0;
      resp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any_req_c) begin
            cur_id  <= win_id_c;
            rr_ptr  <= next_ptr_c;
            m_write <= req_write[win_id_c];
            m_sel   <= req_sel[{win_id_c, 1'b0} +: SW];
            m_addr  <= req_addr[{win_id_c, 3'b000} +: DW];
            m_wdata <= req_wdata[{win_id_c, 3'b000} +: DW];
            m_start <= 1'b1;
            busy    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          // Completion takes priority over a timeout landing in the same cycle.
          if (m_stable) begin
            resp_rdata <= m_write ? '0 : m_rdata;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            resp_id    <= cur_id;
            m_sel      <= '0;
            state      <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            resp_id    <= cur_id;
            m_sel      <= '0;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_request_arbiter.sv
// Directed self-checking bench for apb_request_arbiter (NREQ=2, TIMEOUT=8).
module tb_apb_request_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CW      = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_write;
  logic [2*NREQ-1:0] req_sel;
  logic [8*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic [7:0]        resp_rdata;
  logic              resp_err;
  logic              m_start;
  logic              m_write;
  logic [1:0]        m_sel;
  logic [7:0]        m_addr;
  logic [7:0]        m_wdata;
  logic              m_stable;
  logic [7:0]        m_rdata;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  apb_request_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_sel    (req_sel),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .m_start    (m_start),
    .m_write    (m_write),
    .m_sel      (m_sel),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_stable   (m_stable),
    .m_rdata    (m_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic wr, input logic [1:0] sel,
                         input logic [7:0] addr, input logic [7:0] wd);
    req_valid[id]         = 1'b1;
    req_write[id]         = wr;
    req_sel[2*id +: 2]    = sel;
    req_addr[8*id +: 8]   = addr;
    req_wdata[8*id +: 8]  = wd;
  endtask

  // Runs one transfer from the IDLE grant cycle through RESP and back to IDLE.
  // stable_at = WAIT cycle (1-based) in which the master reports stable; 0 = never.
  task automatic xfer(input string tag, input int id, input logic wr, input logic [1:0] sel,
                      input logic [7:0] addr, input logic [7:0] wd, input bit hold,
                      input bit issue_stable, input int stable_at, input logic [7:0] mrd,
                      input logic [7:0] exp_rd, input logic exp_err, input int exp_wait);
    int w;
    bit got;
    logic [NREQ-1:0] exp_rdy;
    #1;
    exp_rdy     = '0;
    exp_rdy[id] = 1'b1;
    check_eq({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    tick();
    check_eq({tag, ".start"}, 32'(m_start), 32'd1);
    check_eq({tag, ".sel"},   32'(m_sel),   32'(sel));
    check_eq({tag, ".addr"},  32'(m_addr),  32'(addr));
    check_eq({tag, ".wdata"}, 32'(m_wdata), 32'(wd));
    check_eq({tag, ".write"}, 32'(m_write), 32'(wr));
    check_eq({tag, ".busy"},  32'(busy),    32'd1);
    if (!hold) req_valid[id] = 1'b0;
    m_stable = issue_stable;
    m_rdata  = mrd;
    w   = 0;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      w++;
      if (w == 1) begin
        check_eq({tag, ".wait_start"}, 32'(m_start), 32'd0);
        check_eq({tag, ".wait_sel"},   32'(m_sel),   32'(sel));
      end
      m_stable = (w == stable_at);
    end
    m_stable = 1'b0;
    check_eq({tag, ".resp_seen"},  32'(got),        32'd1);
    check_eq({tag, ".wait_cyc"},   32'(w),          32'(exp_wait));
    check_eq({tag, ".resp_id"},    32'(resp_id),    32'(id));
    check_eq({tag, ".resp_rdata"}, 32'(resp_rdata), 32'(exp_rd));
    check_eq({tag, ".resp_err"},   32'(resp_err),   32'(exp_err));
    check_eq({tag, ".resp_sel0"},  32'(m_sel),      32'd0);
    tick();
    check_eq({tag, ".idle_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, ".idle_busy"},  32'(busy),       32'd0);
    check_eq({tag, ".idle_hold"},  32'(resp_rdata), 32'(exp_rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_sel   = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_stable  = 1'b0;
    m_rdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b01;
    #1;
    check_eq("rst.ready", 32'(req_ready),  32'd0);
    check_eq("rst.sel",   32'(m_sel),      32'd0);
    check_eq("rst.start", 32'(m_start),    32'd0);
    check_eq("rst.busy",  32'(busy),       32'd0);
    check_eq("rst.valid", 32'(resp_valid), 32'd0);
    check_eq("rst.rdata", 32'(resp_rdata), 32'd0);
    req_valid = '0;
    reset     = 1'b0;
    tick();
    check_eq("idle.noreq_ready", 32'(req_ready), 32'd0);
    check_eq("idle.busy",        32'(busy),      32'd0);

    // Single write, stable in third WAIT cycle; write returns rdata 0.
    set_req(0, 1'b1, 2'd1, 8'h01, 8'h05);
    xfer("wr0", 0, 1'b1, 2'd1, 8'h01, 8'h05, 1'b0, 1'b0, 3, 8'hEE, 8'h00, 1'b0, 3);

    // Read-back by requester 1 at minimum latency.
    set_req(1, 1'b0, 2'd1, 8'h01, 8'h00);
    xfer("rd1", 1, 1'b0, 2'd1, 8'h01, 8'h00, 1'b0, 1'b0, 1, 8'h05, 8'h05, 1'b0, 1);

    // Contention: both held, alternate 0,1,0,1.
    set_req(0, 1'b1, 2'd1, 8'h10, 8'h11);
    set_req(1, 1'b0, 2'd2, 8'h20, 8'h00);
    xfer("c0", 0, 1'b1, 2'd1, 8'h10, 8'h11, 1'b1, 1'b0, 2, 8'h3C, 8'h00, 1'b0, 2);
    xfer("c1", 1, 1'b0, 2'd2, 8'h20, 8'h00, 1'b1, 1'b0, 1, 8'hA5, 8'hA5, 1'b0, 1);
    xfer("c2", 0, 1'b1, 2'd1, 8'h10, 8'h11, 1'b1, 1'b0, 1, 8'h3C, 8'h00, 1'b0, 1);
    xfer("c3", 1, 1'b0, 2'd2, 8'h20, 8'h00, 1'b1, 1'b0, 3, 8'h5A, 8'h5A, 1'b0, 3);
    req_valid = '0;

    // Timeout after exactly TIMEOUT WAIT cycles, then normal service.
    set_req(0, 1'b1, 2'd3, 8'h3F, 8'hC3);
    xfer("tmo", 0, 1'b1, 2'd3, 8'h3F, 8'hC3, 1'b0, 1'b0, 0, 8'hFF, 8'h00, 1'b1, 8);
    set_req(1, 1'b0, 2'd1, 8'h02, 8'h00);
    xfer("post_tmo", 1, 1'b0, 2'd1, 8'h02, 8'h00, 1'b0, 1'b0, 2, 8'h77, 8'h77, 1'b0, 2);

    // Stable in the same cycle as the timeout: stable wins.
    set_req(0, 1'b0, 2'd1, 8'h40, 8'h00);
    xfer("tie", 0, 1'b0, 2'd1, 8'h40, 8'h00, 1'b0, 1'b0, 8, 8'h99, 8'h99, 1'b0, 8);

    // Stable level during ISSUE is ignored.
    set_req(1, 1'b0, 2'd2, 8'h05, 8'h00);
    xfer("iss_stb", 1, 1'b0, 2'd2, 8'h05, 8'h00, 1'b0, 1'b1, 2, 8'h42, 8'h42, 1'b0, 2);

    // Async reset in mid-WAIT; requester 0 gets the pointer back.
    set_req(0, 1'b1, 2'd1, 8'h07, 8'h08);
    #1;
    check_eq("mid.ready", 32'(req_ready), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    check_eq("mid.busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid.sel",   32'(m_sel),      32'd0);
    check_eq("mid.start", 32'(m_start),    32'd0);
    check_eq("mid.busy",  32'(busy),       32'd0);
    check_eq("mid.valid", 32'(resp_valid), 32'd0);
    check_eq("mid.rdata", 32'(resp_rdata), 32'd0);
    tick();
    check_eq("mid.valid2", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    set_req(0, 1'b0, 2'd1, 8'h01, 8'h00);
    set_req(1, 1'b0, 2'd2, 8'h02, 8'h00);
    xfer("rst_r0", 0, 1'b0, 2'd1, 8'h01, 8'h00, 1'b0, 1'b0, 1, 8'h05, 8'h05, 1'b0, 1);
    xfer("rst_r1", 1, 1'b0, 2'd2, 8'h02, 8'h00, 1'b0, 1'b0, 1, 8'h06, 8'h06, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
